// File: rtl/led_frame_server.sv
// Double-banked GRB pixel source for a WS2812B strand driver: one bank is streamed
// on request while the host fills the other; a commit swaps banks at a frame boundary.
module led_frame_server #(
  parameter int unsigned CLOCK_SPEED = 100_000_000,
  parameter int unsigned FRAME_HZ    = 60,
  parameter int unsigned NUM_LEDS    = 20,
  localparam int unsigned CounterWidth = $clog2(NUM_LEDS),
  localparam int unsigned ColorWidth   = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    wr_en_in,
  input  logic [CounterWidth-1:0] wr_addr_in,
  input  logic [ColorWidth-1:0]   wr_green_in,
  input  logic [ColorWidth-1:0]   wr_red_in,
  input  logic [ColorWidth-1:0]   wr_blue_in,
  output logic                    wr_ready_out,
  input  logic                    commit_in,
  output logic                    commit_done_out,
  input  logic [CounterWidth-1:0] request_in,
  input  logic                    request_valid_in,
  output logic [ColorWidth-1:0]   green_out,
  output logic [ColorWidth-1:0]   red_out,
  output logic [ColorWidth-1:0]   blue_out,
  output logic                    color_valid_out,
  output logic                    frame_start_out,
  output logic                    frame_overrun_out
);

  localparam int unsigned FramePeriodCyc = CLOCK_SPEED / FRAME_HZ;
  localparam int unsigned TimerWidth     = $clog2(FramePeriodCyc);
  localparam int unsigned SentWidth      = $clog2(NUM_LEDS + 1);
  localparam int unsigned PixelWidth     = 3 * ColorWidth;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] READ1  = 2'd2;
  localparam logic [1:0] READ2  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [TimerWidth-1:0]   timer_q, timer_d;
  logic [SentWidth-1:0]    sent_q, sent_d;
  logic                    bank_sel_q, bank_sel_d;
  logic                    pending_q, pending_d;
  logic [CounterWidth-1:0] rd_addr_q, rd_addr_d;
  logic [PixelWidth-1:0]   rd_data_q, rd_data_d;
  logic [PixelWidth-1:0]   pixel_q, pixel_d;
  logic                    color_valid_q, color_valid_d;

  logic [PixelWidth-1:0] mem0 [NUM_LEDS];
  logic [PixelWidth-1:0] mem1 [NUM_LEDS];

  logic tick;
  logic wr_fire;
  logic rd_in_range;
  logic frame_start;
  logic commit_done;
  logic overrun;

  assign tick        = (timer_q == TimerWidth'(FramePeriodCyc - 1));
  assign wr_fire     = wr_en_in && !pending_q && (32'(wr_addr_in) < NUM_LEDS);
  assign rd_in_range = (32'(rd_addr_q) < NUM_LEDS);

  always_comb begin
    timer_d       = tick ? '0 : timer_q + TimerWidth'(1);
    state_d       = state_q;
    sent_d        = sent_q;
    bank_sel_d    = bank_sel_q;
    pending_d     = pending_q;
    rd_addr_d     = rd_addr_q;
    rd_data_d     = rd_data_q;
    pixel_d       = pixel_q;
    color_valid_d = 1'b0;
    frame_start   = 1'b0;
    commit_done   = 1'b0;
    overrun       = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          if (pending_q) begin
            bank_sel_d  = ~bank_sel_q;
            pending_d   = 1'b0;
            commit_done = 1'b1;
          end
          frame_start = 1'b1;
          sent_d      = '0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (request_valid_in) begin
          rd_addr_d = request_in;
          state_d   = READ1;
        end
      end
      READ1: begin
        if (!rd_in_range)    rd_data_d = '0;
        else if (bank_sel_q) rd_data_d = mem1[rd_addr_q];
        else                 rd_data_d = mem0[rd_addr_q];
        state_d = READ2;
      end
      READ2: begin
        pixel_d       = rd_data_q;
        color_valid_d = 1'b1;
        sent_d        = sent_q + SentWidth'(1);
        state_d       = (32'(sent_q) + 1 == NUM_LEDS) ? IDLE : STREAM;
      end
      default: state_d = IDLE;
    endcase
    // A tick outside IDLE is reported and dropped; streaming carries on.
    if (tick && state_q != IDLE) overrun = 1'b1;
    // Evaluated after the swap so a commit in the swap cycle re-arms for the next frame.
    if (commit_in) pending_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      sent_q        <= '0;
      bank_sel_q    <= 1'b0;
      pending_q     <= 1'b0;
      rd_addr_q     <= '0;
      rd_data_q     <= '0;
      pixel_q       <= '0;
      color_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      sent_q        <= sent_d;
      bank_sel_q    <= bank_sel_d;
      pending_q     <= pending_d;
      rd_addr_q     <= rd_addr_d;
      rd_data_q     <= rd_data_d;
      pixel_q       <= pixel_d;
      color_valid_q <= color_valid_d;
    end
  end

  // Host always writes the bank that is not on display.
  always_ff @(posedge clk_in) begin
    if (wr_fire) begin
      if (bank_sel_q) mem0[wr_addr_in] <= {wr_green_in, wr_red_in, wr_blue_in};
      else            mem1[wr_addr_in] <= {wr_green_in, wr_red_in, wr_blue_in};
    end
  end

  assign wr_ready_out                   = !pending_q;
  assign commit_done_out                = commit_done;
  assign frame_start_out                = frame_start;
  assign frame_overrun_out              = overrun;
  assign color_valid_out                = color_valid_q;
  assign {green_out, red_out, blue_out} = pixel_q;

endmodule

// File: tb/tb_led_frame_server.sv
// Directed-sequence bench for led_frame_server with random pixel data, checked against
// a bank/commit/frame-schedule reference model kept in the bench.
module tb_led_frame_server;

  localparam int unsigned N   = 4;
  localparam int unsigned CLK = 100_000_000;
  localparam int unsigned FHZ = 500_000;
  localparam int unsigned PER = CLK / FHZ;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, wr_en, commit, req_valid;
  logic [1:0] wr_addr, req_idx;
  logic [7:0] wg, wrr, wb;
  logic       wr_ready, commit_done, cv, fs, ov;
  logic [7:0] g_o, r_o, b_o;

  logic       rst5_n, req5_valid;
  logic [2:0] req5_idx;
  logic       wr_ready5, commit_done5, cv5, fs5, ov5;
  logic [7:0] g5, r5, b5;

  led_frame_server #(.CLOCK_SPEED(CLK), .FRAME_HZ(FHZ), .NUM_LEDS(N)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .wr_en_in(wr_en), .wr_addr_in(wr_addr),
    .wr_green_in(wg), .wr_red_in(wrr), .wr_blue_in(wb), .wr_ready_out(wr_ready),
    .commit_in(commit), .commit_done_out(commit_done), .request_in(req_idx),
    .request_valid_in(req_valid), .green_out(g_o), .red_out(r_o), .blue_out(b_o),
    .color_valid_out(cv), .frame_start_out(fs), .frame_overrun_out(ov)
  );

  // Five-LED instance: its 3-bit index can express out-of-range requests.
  led_frame_server #(.CLOCK_SPEED(CLK), .FRAME_HZ(FHZ), .NUM_LEDS(5)) u_dut5 (
    .clk_in(clk), .rst_n_in(rst5_n), .wr_en_in(1'b0), .wr_addr_in(3'd0),
    .wr_green_in(8'd0), .wr_red_in(8'd0), .wr_blue_in(8'd0), .wr_ready_out(wr_ready5),
    .commit_in(1'b0), .commit_done_out(commit_done5), .request_in(req5_idx),
    .request_valid_in(req5_valid), .green_out(g5), .red_out(r5), .blue_out(b5),
    .color_valid_out(cv5), .frame_start_out(fs5), .frame_overrun_out(ov5)
  );

  int tests = 0;
  int fails = 0;
  int unsigned cyc, cyc5;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0; else cyc <= cyc + 1;
  always @(posedge clk or negedge rst5_n)
    if (!rst5_n) cyc5 <= 0; else cyc5 <= cyc5 + 1;

  // Reference model: bank contents, displayed bank, pending commit, frame progress.
  logic [23:0] mem_m [2][N];
  int          dbank;
  bit          pending;
  bit          idle;
  int          sent;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = addr[1:0]; {wg, wrr, wb} = d;
    step();
    wr_en = 1'b0;
    if (!pending && addr < N) mem_m[1 - dbank][addr] = d;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
    pending = 1'b1;
    check("wr_ready_after_commit", wr_ready, 0);
  endtask

  task automatic to_tick(input string tag);
    for (int i = 0; i <= PER && (cyc % PER) != PER - 1; i++) step();
    if (idle) begin
      check({tag, "_frame_start"}, fs, 1);
      check({tag, "_commit_done"}, commit_done, pending);
      check({tag, "_overrun"}, ov, 0);
      if (pending) begin
        dbank = 1 - dbank;
        pending = 1'b0;
      end
      idle = 1'b0;
      sent = 0;
    end else begin
      check({tag, "_frame_start"}, fs, 0);
      check({tag, "_commit_done"}, commit_done, 0);
      check({tag, "_overrun"}, ov, 1);
    end
    step();
    check({tag, "_pulse_width"}, {fs, commit_done, ov}, 0);
    check({tag, "_wr_ready"}, wr_ready, !pending);
  endtask

  task automatic req(input int idx, input int hold);
    logic [23:0] exp;
    exp = (idx < N) ? mem_m[dbank][idx] : 24'h0;
    req_idx = idx[1:0];
    req_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k >= hold) req_valid = 1'b0;
      if (k < 3) check("cv_before_E2", cv, 0);
    end
    check("cv_at_E2", cv, 1);
    check("grb_at_E2", {g_o, r_o, b_o}, exp);
    sent++;
    if (sent == N) idle = 1'b1;
    step();
    check("cv_after_E2", cv, 0);
    check("grb_hold", {g_o, r_o, b_o}, exp);
    step();
    check("cv_no_extra", cv, 0);
  endtask

  initial begin
    logic [23:0] d;
    rst_n = 1'b0; rst5_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wg = '0; wrr = '0; wb = '0;
    commit = 1'b0; req_valid = 1'b0; req_idx = '0;
    req5_valid = 1'b0; req5_idx = '0;
    dbank = 0; pending = 1'b0; idle = 1'b1; sent = 0;
    repeat (3) step();
    check("rst_outputs", {cv, fs, ov, commit_done}, 0);
    check("rst_grb", {g_o, r_o, b_o}, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_wr_ready5", wr_ready5, 1);
    rst_n = 1'b1;

    // Basic frame: fixed pattern into bank 1, swapped in at the first tick.
    for (int i = 0; i < N; i++) begin
      d = {3{8'(i * 8'h11)}};
      wr(i, d);
    end
    do_commit();
    to_tick("frame1");
    check("frame1_bank", dbank, 1);
    for (int i = 0; i < N; i++) req(i, 1);

    // Held request, then a no-tear commit with new random data mid-stream.
    to_tick("frame2");
    req(2, 3);
    for (int i = 0; i < N; i++) wr(i, 24'($urandom));
    do_commit();
    d = mem_m[0][1] ^ 24'hFFFFFF;
    wr(1, d);
    check("wr_ready_pending", wr_ready, 0);
    req(0, 1); req(1, 1); req(3, 1);
    to_tick("frame3");
    for (int i = 0; i < N; i++) req(i, 1);

    // Overrun: no requests after frame start; a commit stays pending.
    to_tick("frame4");
    do_commit();
    to_tick("overrun1");
    to_tick("overrun2");

    // Reset while a read is in flight (state READ2).
    req_idx = 2'd1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("rst_mid_cv", cv, 0);
    check("rst_mid_fs", fs, 0);
    check("rst_mid_wr_ready", wr_ready, 1);
    step(); step();
    check("rst_hold_cv", cv, 0);
    rst_n = 1'b1;
    dbank = 0; pending = 1'b0; idle = 1'b1; sent = 0;
    for (int i = 0; i < N; i++) wr(i, 24'($urandom));
    to_tick("post_rst1");
    for (int i = 0; i < N; i++) req(i, 1);
    do_commit();
    to_tick("post_rst2");
    for (int i = 0; i < N; i++) req(i, 1);

    // Out-of-range requests on the five-LED instance still count toward the frame.
    rst5_n = 1'b1;
    for (int i = 0; i <= PER && (cyc5 % PER) != PER - 1; i++) step();
    check("oor_frame_start", fs5, 1);
    check("oor_no_overrun", ov5, 0);
    step();
    for (int k = 0; k < 5; k++) begin
      req5_idx = 3'(5 + (k % 3));
      req5_valid = 1'b1;
      step();
      req5_valid = 1'b0;
      step();
      check("oor_cv_E1", cv5, 0);
      step();
      check("oor_cv_E2", cv5, 1);
      check("oor_grb", {g5, r5, b5}, 0);
      step();
    end
    for (int i = 0; i <= PER && (cyc5 % PER) != PER - 1; i++) step();
    check("oor_next_frame_start", fs5, 1);
    check("oor_next_no_overrun", ov5, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_frame_server.md
Name: led_frame_server

Overview:
- Upstream pixel source for the WS2812B strand driver.
- Holds two NUM_LEDS-deep GRB frame banks: the host writes one bank while the other is streamed.
- At each frame period it pulses frame_start_out, which drives the driver's force_reset.
- It answers the driver's LED-index requests with one colour triple plus a single-cycle color_valid_out pulse.
- A host commit swaps the two banks at a frame boundary, so a frame is never torn.

Parameters:
- CLOCK_SPEED, 100_000_000: clock frequency in Hz.
- FRAME_HZ, 60: frame refresh rate. FramePeriodCyc = CLOCK_SPEED / FRAME_HZ, integer division.
- NUM_LEDS, 20: LEDs per strand, and the depth of each bank. CounterWidth = $clog2(NUM_LEDS).
- ColorWidth, 8 (localparam): bits per colour channel.

Ports:
- clk_in, input, 1: system clock.
- rst_n_in, input, 1: reset, asynchronous and active-low.
- wr_en_in, input, 1: host write strobe.
- wr_addr_in, input, CounterWidth: host write LED index.
- wr_green_in / wr_red_in / wr_blue_in, input, ColorWidth each: host write colour.
- wr_ready_out, output, 1: host writes are accepted while this is high.
- commit_in, input, 1: single-cycle pulse requesting a bank swap.
- commit_done_out, output, 1: single-cycle pulse in the cycle the swap takes effect.
- request_in, input, CounterWidth: LED index requested by the driver.
- request_valid_in, input, 1: qualifies request_in.
- green_out / red_out / blue_out, output, ColorWidth each: pixel colour.
- color_valid_out, output, 1: single-cycle pulse qualifying the colour outputs.
- frame_start_out, output, 1: single-cycle pulse; connects to the driver's force_reset.
- frame_overrun_out, output, 1: single-cycle pulse when a frame tick arrives while the previous frame is still streaming.

Behaviour:
Reset values:
- All outputs 0, except wr_ready_out = 1.
- State IDLE, display bank = 0, write bank = 1.
- commit_pending = 0; frame timer and sent counter = 0.
- Bank memory is not reset; its contents are undefined until written.

Frame timer:
- Free-running, counts 0 .. FramePeriodCyc-1 and wraps.
- Generates a one-cycle tick when the count equals FramePeriodCyc-1.

FSM states: IDLE, STREAM, READ1, READ2.
- IDLE, on tick:
  - If commit_pending: flip the bank select, clear commit_pending, pulse commit_done_out.
  - Pulse frame_start_out, clear the sent counter, go to STREAM.
  - commit_done_out and frame_start_out assert in the same cycle.
- STREAM, on request_valid_in: register request_in as the read address and go to READ1.
- READ1: synchronous read of the display bank; go to READ2.
- READ2:
  - Drive the registered colour and pulse color_valid_out.
  - Increment the sent counter.
  - If the counter reaches NUM_LEDS, go to IDLE; otherwise go to STREAM.
- Latency: request_valid_in sampled at edge E0 gives color_valid_out high for exactly the cycle following edge E2.
- request_valid_in is ignored in IDLE, READ1 and READ2. The driver never issues a new request before consuming the previous colour.
- Read address >= NUM_LEDS: colour outputs are 0, color_valid_out still pulses, and the pixel still counts toward NUM_LEDS.
- Colour outputs hold their last value when color_valid_out is low.

Frame overrun:
- A tick while not in IDLE pulses frame_overrun_out and is otherwise dropped.
- Streaming continues; no frame_start_out is issued.

Commit and write path:
- commit_in sets commit_pending.
- commit_in while already pending has no further effect.
- wr_ready_out = !commit_pending.
- wr_en_in with wr_ready_out high writes the colour to the write bank at wr_addr_in on the next edge.
- wr_en_in with wr_ready_out low is dropped.
- wr_addr_in >= NUM_LEDS is dropped.
- A write and a commit_in in the same cycle: the write lands first, then commit_pending sets.
- Reads and writes always target different banks, so there are no read/write collisions.

Asynchronous reset:
- Asserting rst_n_in mid-stream returns to the reset state immediately.
- Any pending commit is lost; color_valid_out and frame_start_out drop at once.

Test Plan:
Parameters for all scenarios: NUM_LEDS=4, CLOCK_SPEED=100_000_000, FRAME_HZ=500_000, giving FramePeriodCyc = 200.

1. Basic frame:
   - Stimulus: write bank 1 with {G,R,B} = idx*0x11 for idx 0..3; pulse commit_in; wait for the tick; respond to each color_valid_out by raising request_valid_in with idx 0..3.
   - Required response: commit_done_out and frame_start_out pulse together at cycle 199; colours 0x00, 0x11, 0x22, 0x33 each appear with color_valid_out exactly 2 cycles after their request; FSM returns to IDLE after the 4th pixel.
2. Latency and ignore:
   - Stimulus: hold request_valid_in high for 3 consecutive cycles with idx 2.
   - Required response: exactly one color_valid_out pulse, 2 cycles after the first request; the next request is accepted only after return to STREAM.
3. No-tear commit:
   - Stimulus: commit_in mid-stream after writing new data.
   - Required response: the current frame completes with old data; wr_ready_out stays low until the next tick; writes during that window are dropped (verify by reading back the old value 2 frames later).
4. Overrun:
   - Stimulus: after the first frame_start_out, never issue a request.
   - Required response: frame_overrun_out pulses at cycle 399 and 599; no further frame_start_out.
5. Out-of-range read:
   - Stimulus: request idx 5.
   - Required response: colour outputs = 0 with a color_valid_out pulse; the pixel counts toward the frame.
6. Reset mid-operation:
   - Stimulus: drop rst_n_in between READ1 and READ2.
   - Required response: color_valid_out never asserts; wr_ready_out = 1; after release, the first frame_start_out occurs 200 cycles later with display bank 0.
